// File: rtl/serial_parity_pkg.sv
// Shared types and constants for the serial parity framer.
// Not timed: this package holds only type and constant definitions.
// No flow control lives here.
package serial_parity_pkg;

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        PARITY,
        GAP
    } state_t;

    localparam logic LINE_IDLE = 1'b1;
    localparam logic START_BIT = 1'b0;

    function automatic bit params_ok(input int data_w, input int idle_gap, input int cnt_w);
        return (data_w >= 2) && (data_w <= 32) &&
               (idle_gap >= 0) && (idle_gap <= 15) &&
               (cnt_w >= 1);
    endfunction

endpackage

// File: rtl/parity_shift_accum.sv
// Shift register that presents the word LSB-first and a running XOR of the bits shifted out.
// Latency: a load or shift takes effect at the next clk edge.
// No backpressure: the parent FSM decides when to load, shift or clear.
module parity_shift_accum #(
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              load,
    input  logic [DATA_W-1:0] load_dat,
    input  logic              shift_en,
    input  logic              clr,
    output logic              lsb,
    output logic              acc
);

    logic [DATA_W-1:0] shreg;

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            shreg <= '0;
            acc   <= 1'b0;
        end else begin
            if (load)
                shreg <= load_dat;
            else if (shift_en)
                shreg <= shreg >> 1;

            if (clr)
                acc <= 1'b0;
            else if (shift_en)
                acc <= acc ^ shreg[0];
        end
    end

    assign lsb = shreg[0];

endmodule

// File: rtl/serial_parity_framer.sv
// Serialises accepted words as start bit, LSB-first data, parity bit, then idle gap slots.
// Latency: a word accepted at edge N drives its start bit from cycle N+1; slots advance on bit_en.
// Backpressure: in_ready is high only in IDLE, and all outputs decode registered state.
module serial_parity_framer
    import serial_parity_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int PARITY_ODD = 0,
    parameter int IDLE_GAP   = 1,
    parameter int CNT_W      = 16
) (
    input  logic              clk,
    input  logic              arst,
    input  logic              bit_en,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              out_bit,
    output logic              out_valid,
    output logic              out_start,
    output logic              out_last,
    output logic              busy,
    output logic [CNT_W-1:0]  frame_cnt
);

    localparam int BC_W = $clog2(DATA_W);

    if (!params_ok(DATA_W, IDLE_GAP, CNT_W)) begin : g_param_err
        $error("serial_parity_framer: parameter out of range");
    end

    state_t          state, state_nxt;
    logic [BC_W-1:0] bit_cnt;
    logic [3:0]      gap_cnt;
    logic            accept, shift_en, data_done, gap_done, parity_exit;
    logic            sh_lsb, sh_acc;

    assign accept      = (state == IDLE) && in_valid;
    assign shift_en    = (state == DATA) && bit_en;
    assign parity_exit = (state == PARITY) && bit_en;
    assign data_done   = (bit_cnt == BC_W'(DATA_W - 1));
    assign gap_done    = (int'(gap_cnt) == IDLE_GAP - 1);

    parity_shift_accum #(
        .DATA_W (DATA_W)
    ) u_shift (
        .clk      (clk),
        .arst     (arst),
        .load     (accept),
        .load_dat (in_data),
        .shift_en (shift_en),
        .clr      (accept),
        .lsb      (sh_lsb),
        .acc      (sh_acc)
    );

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            gap_cnt   <= '0;
            frame_cnt <= '0;
        end else begin
            state <= state_nxt;

            if (accept)
                bit_cnt <= '0;
            else if (shift_en)
                bit_cnt <= bit_cnt + BC_W'(1);

            if (parity_exit)
                gap_cnt <= '0;
            else if ((state == GAP) && bit_en)
                gap_cnt <= gap_cnt + 4'd1;

            if (parity_exit)
                frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (in_valid)             state_nxt = START;
            START:   if (bit_en)               state_nxt = DATA;
            DATA:    if (bit_en && data_done)  state_nxt = PARITY;
            PARITY:  if (bit_en)               state_nxt = (IDLE_GAP > 0) ? GAP : IDLE;
            GAP:     if (bit_en && gap_done)   state_nxt = IDLE;
            default:                           state_nxt = IDLE;
        endcase
    end

    // Moore decode: nothing below looks at in_valid, in_data or bit_en.
    always_comb begin
        out_bit   = LINE_IDLE;
        out_valid = 1'b0;
        out_start = 1'b0;
        out_last  = 1'b0;
        case (state)
            START: begin
                out_bit   = START_BIT;
                out_valid = 1'b1;
                out_start = 1'b1;
            end
            DATA: begin
                out_bit   = sh_lsb;
                out_valid = 1'b1;
            end
            PARITY: begin
                out_bit   = sh_acc ^ (PARITY_ODD != 0);
                out_valid = 1'b1;
                out_last  = 1'b1;
            end
            default: ;
        endcase
    end

    assign in_ready = (state == IDLE);
    assign busy     = (state != IDLE);

endmodule

// File: tb/tb_serial_parity_framer.sv
// Directed bench for serial_parity_framer: four instances cover even/odd parity, zero gap and a narrow counter.
module tb_serial_parity_framer;

    logic       clk = 1'b0;
    logic       arst;
    logic       bit_en;
    logic [7:0] in_data;
    logic       va, vb, vc, vd;

    logic a_ready, a_bit, a_ovld, a_start, a_last, a_busy;
    logic b_ready, b_bit, b_ovld, b_start, b_last, b_busy;
    logic c_ready, c_bit, c_ovld, c_start, c_last, c_busy;
    logic d_ready, d_bit, d_ovld, d_start, d_last, d_busy;
    logic [15:0] a_cnt, b_cnt, c_cnt;
    logic [3:0]  d_cnt;

    int n_checks = 0;
    int n_fail   = 0;
    logic [0:10] seq;

    always #5 clk = ~clk;

    serial_parity_framer #(.DATA_W(8), .PARITY_ODD(0), .IDLE_GAP(1), .CNT_W(16)) u_a (
        .clk(clk), .arst(arst), .bit_en(bit_en), .in_data(in_data), .in_valid(va),
        .in_ready(a_ready), .out_bit(a_bit), .out_valid(a_ovld), .out_start(a_start),
        .out_last(a_last), .busy(a_busy), .frame_cnt(a_cnt));

    serial_parity_framer #(.DATA_W(8), .PARITY_ODD(1), .IDLE_GAP(1), .CNT_W(16)) u_b (
        .clk(clk), .arst(arst), .bit_en(bit_en), .in_data(in_data), .in_valid(vb),
        .in_ready(b_ready), .out_bit(b_bit), .out_valid(b_ovld), .out_start(b_start),
        .out_last(b_last), .busy(b_busy), .frame_cnt(b_cnt));

    serial_parity_framer #(.DATA_W(8), .PARITY_ODD(0), .IDLE_GAP(0), .CNT_W(16)) u_c (
        .clk(clk), .arst(arst), .bit_en(bit_en), .in_data(in_data), .in_valid(vc),
        .in_ready(c_ready), .out_bit(c_bit), .out_valid(c_ovld), .out_start(c_start),
        .out_last(c_last), .busy(c_busy), .frame_cnt(c_cnt));

    serial_parity_framer #(.DATA_W(8), .PARITY_ODD(0), .IDLE_GAP(1), .CNT_W(4)) u_d (
        .clk(clk), .arst(arst), .bit_en(bit_en), .in_data(in_data), .in_valid(vd),
        .in_ready(d_ready), .out_bit(d_bit), .out_valid(d_ovld), .out_start(d_start),
        .out_last(d_last), .busy(d_busy), .frame_cnt(d_cnt));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Expected line value for slot s of an 8-bit even/odd frame (9 = parity, 10+ = high).
    function automatic logic exp_bit(input logic [7:0] w, input int s, input logic odd);
        if (s == 0)      return 1'b0;
        else if (s <= 8) return w[s-1];
        else if (s == 9) return (^w) ^ odd;
        else             return 1'b1;
    endfunction

    initial begin
        arst = 1'b1; bit_en = 1'b0; in_data = 8'h00;
        va = 1'b0; vb = 1'b0; vc = 1'b0; vd = 1'b0;
        tick(); tick();

        check("rst_bit",   a_bit,   1);
        check("rst_valid", a_ovld,  0);
        check("rst_start", a_start, 0);
        check("rst_last",  a_last,  0);
        check("rst_busy",  a_busy,  0);
        check("rst_ready", a_ready, 1);
        check("rst_cnt",   a_cnt,   0);
        check("rst_cnt_d", d_cnt,   0);
        arst = 1'b0;
        tick();

        // 0xA5 with bit_en held high
        seq = 11'b01010010101;
        in_data = 8'hA5; va = 1'b1; bit_en = 1'b1;
        tick();
        va = 1'b0;
        for (int i = 0; i < 11; i++) begin
            check("a5_bit",   a_bit,   seq[i]);
            check("a5_start", a_start, (i == 0));
            check("a5_last",  a_last,  (i == 9));
            check("a5_valid", a_ovld,  (i < 10));
            if (i < 10) tick();
        end
        check("a5_gap_cnt",   a_cnt,   1);
        check("a5_gap_ready", a_ready, 0);
        tick();
        check("a5_c12_ready", a_ready, 1);
        check("a5_c12_bit",   a_bit,   1);

        // 0x07: even parity drives 1, odd parity drives 0
        in_data = 8'h07; va = 1'b1; vb = 1'b1;
        tick();
        va = 1'b0; vb = 1'b0;
        repeat (9) tick();
        check("p07_even_last", a_last, 1);
        check("p07_odd_last",  b_last, 1);
        check("p07_even_bit",  a_bit,  1);
        check("p07_odd_bit",   b_bit,  0);
        repeat (2) tick();
        check("p07_ready", a_ready, 1);
        check("p07_cnt_a", a_cnt,   2);
        check("p07_cnt_b", b_cnt,   1);

        // bit_en every 4th cycle, stray in_valid pulses while busy
        bit_en = 1'b0; in_data = 8'h3C; va = 1'b1;
        tick();
        va = 1'b0;
        for (int k = 0; k < 45; k++) begin
            check("slow_bit",   a_bit,   exp_bit(8'h3C, k / 4, 1'b0));
            check("slow_start", a_start, (k / 4 == 0));
            check("slow_last",  a_last,  (k / 4 == 9));
            check("slow_ready", a_ready, (k / 4 == 11));
            if (k < 44) begin
                bit_en  = (k % 4 == 3);
                va      = (k == 6 || k == 21);
                in_data = va ? 8'hFF : 8'h3C;
                tick();
            end
        end
        check("slow_cnt", a_cnt, 3);
        in_data = 8'h81; va = 1'b1; bit_en = 1'b0;
        tick();
        va = 1'b0;
        check("second_start", a_start, 1);
        check("second_busy",  a_busy,  1);
        bit_en = 1'b1;
        repeat (9) tick();
        check("second_last", a_last, 1);
        check("second_par",  a_bit,  0);
        repeat (2) tick();
        check("second_ready", a_ready, 1);
        check("second_cnt",   a_cnt,   4);

        // IDLE_GAP=0 with in_valid held: 0x00 then 0xFF
        in_data = 8'h00; vc = 1'b1;
        tick();
        in_data = 8'hFF;
        repeat (9) tick();
        check("g0_last1", c_last, 1);
        check("g0_par1",  c_bit,  0);
        tick();
        check("g0_idle_valid", c_ovld,  0);
        check("g0_idle_ready", c_ready, 1);
        check("g0_idle_busy",  c_busy,  0);
        check("g0_idle_bit",   c_bit,   1);
        tick();
        vc = 1'b0;
        check("g0_start2", c_start, 1);
        check("g0_sbit2",  c_bit,   0);
        repeat (9) tick();
        check("g0_last2", c_last, 1);
        check("g0_par2",  c_bit,  0);
        tick();
        check("g0_ready_end", c_ready, 1);
        check("g0_cnt",       c_cnt,   2);

        // reset during DATA of the third frame
        in_data = 8'h55; vc = 1'b1;
        tick();
        vc = 1'b0;
        repeat (3) tick();
        check("mid_in_data", c_ovld, 1);
        arst = 1'b1;
        #1;
        check("abort_bit",   c_bit,   1);
        check("abort_valid", c_ovld,  0);
        check("abort_start", c_start, 0);
        check("abort_busy",  c_busy,  0);
        check("abort_ready", c_ready, 1);
        check("abort_cnt",   c_cnt,   0);
        check("abort_cnt_a", a_cnt,   0);
        #2;
        arst = 1'b0;
        tick();
        in_data = 8'h01; vc = 1'b1;
        tick();
        vc = 1'b0;
        repeat (9) tick();
        check("post_last", c_last, 1);
        check("post_par",  c_bit,  1);
        tick();
        check("post_cnt",   c_cnt,   1);
        check("post_ready", c_ready, 1);

        // 4-bit frame counter wraps on the 16th frame
        for (int f = 0; f < 16; f++) begin
            in_data = 8'(f); vd = 1'b1;
            tick();
            vd = 1'b0;
            repeat (9) tick();
            check("wrap_last",     d_last, 1);
            check("wrap_cnt_par",  d_cnt,  f % 16);
            repeat (2) tick();
            check("wrap_cnt_done", d_cnt,  (f + 1) % 16);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
